// File: rtl/study_scorer.sv
// study_scorer
//   Learn-mode engine for the piano. Walks a song held in an external ROM,
//   lights the LED of the note the player must press next, judges each new key
//   press against the stored note and octave, keeps saturating hit and miss
//   counts and turns an idle step into a miss after TIMEOUT_CYCLES.
//
//   ROM entry, MSB first: end_flag(1) octave(2) note(3) length(LEN_BITS).
//   note 0, or any value above NOTE_KEYS, is a rest of (length+1)*REST_UNIT
//   cycles.
//
// Ports
//   clk, rst     clock; asynchronous active-high reset
//   en           mode enable; low sends the engine to IDLE on the next edge
//   start        one-cycle pulse; starts a run from entry 0 when idle
//   strict       1: a wrong press advances; 0: a wrong press retries the entry
//   note_key     debounced, synchronised key levels
//   octave       player's current octave
//   rom_addr     song ROM address (rom_data follows one cycle later)
//   rom_data     song ROM entry
//   note_led     one-hot LED of the goal note (GUIDE only)
//   goal_octave  octave of the current entry
//   hit_pulse    one cycle per correct press
//   miss_pulse   one cycle per wrong press or timeout
//   score        hit count, saturating
//   misses       miss count, saturating
//   idx          current entry index
//   busy         high in every state except IDLE
//   done         one-cycle pulse when a run completes
//
// The FSM state is held in the enum register 'state' for observation.
module study_scorer #(
  parameter int NOTE_KEYS      = 7,
  parameter int LEN_BITS       = 3,
  parameter int SONG_DEPTH     = 64,
  parameter int TIMEOUT_CYCLES = 200_000_000,
  parameter int REST_UNIT      = 25_000_000,
  parameter int SCORE_BITS     = 8,
  localparam int ADDR_W        = $clog2(SONG_DEPTH),
  localparam int ENTRY_W       = 6 + LEN_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  start,
  input  logic                  strict,
  input  logic [NOTE_KEYS-1:0]  note_key,
  input  logic [1:0]            octave,
  output logic [ADDR_W-1:0]     rom_addr,
  input  logic [ENTRY_W-1:0]    rom_data,
  output logic [NOTE_KEYS-1:0]  note_led,
  output logic [1:0]            goal_octave,
  output logic                  hit_pulse,
  output logic                  miss_pulse,
  output logic [SCORE_BITS-1:0] score,
  output logic [SCORE_BITS-1:0] misses,
  output logic [ADDR_W-1:0]     idx,
  output logic                  busy,
  output logic                  done
);

  // The timer serves both the GUIDE timeout and the longest rest.
  localparam longint REST_MAX = longint'(2 ** LEN_BITS) * longint'(REST_UNIT);
  localparam longint TMR_MAX  = (longint'(TIMEOUT_CYCLES) > REST_MAX) ?
                                longint'(TIMEOUT_CYCLES) : REST_MAX;
  localparam int TMR_W = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0]  TIMEOUT_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0]  REST_UNIT_T  = TMR_W'(REST_UNIT);
  localparam logic [TMR_W-1:0]  TMR_ONE      = TMR_W'(1);
  localparam logic [ADDR_W-1:0] IDX_LAST     = ADDR_W'(SONG_DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, LATCH, GUIDE, REST, ADVANCE, DONE
  } state_t;

  state_t               state;
  logic [NOTE_KEYS-1:0] key_prev;
  logic [2:0]           goal_note;
  logic [LEN_BITS-1:0]  goal_len;
  logic                 end_flag;
  logic [TMR_W-1:0]     timer;

  function automatic logic [NOTE_KEYS-1:0] note_onehot(input logic [2:0] n);
    logic [NOTE_KEYS-1:0] v;
    v = '0;
    for (int k = 0; k < NOTE_KEYS; k++)
      if (int'(n) == k + 1) v[k] = 1'b1;
    return v;
  endfunction

  function automatic logic [SCORE_BITS-1:0] sat_inc(input logic [SCORE_BITS-1:0] c);
    return (&c) ? c : c + SCORE_BITS'(1);
  endfunction

  // ROM entry fields
  logic                e_end;
  logic [1:0]          e_oct;
  logic [2:0]          e_note;
  logic [LEN_BITS-1:0] e_len;
  logic                e_is_note;

  assign e_end     = rom_data[ENTRY_W-1];
  assign e_oct     = rom_data[ENTRY_W-2 -: 2];
  assign e_note    = rom_data[LEN_BITS+2 -: 3];
  assign e_len     = rom_data[LEN_BITS-1:0];
  assign e_is_note = (e_note != 3'd0) && (int'(e_note) <= NOTE_KEYS);

  // A press is a rising key level. Comparing the whole new-press vector with
  // the one-hot goal rejects wrong keys and multi-key chords in one test.
  logic [NOTE_KEYS-1:0] new_press;
  logic                 any_press;
  logic                 good_press;
  logic [TMR_W-1:0]     rest_last;

  assign new_press  = note_key & ~key_prev;
  assign any_press  = |new_press;
  assign good_press = (new_press == note_onehot(goal_note)) && (octave == goal_octave);
  assign rest_last  = (TMR_W'(goal_len) + TMR_ONE) * REST_UNIT_T - TMR_ONE;

  assign rom_addr = idx;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      key_prev    <= '0;
      goal_note   <= '0;
      goal_len    <= '0;
      end_flag    <= 1'b0;
      timer       <= '0;
      note_led    <= '0;
      goal_octave <= '0;
      hit_pulse   <= 1'b0;
      miss_pulse  <= 1'b0;
      score       <= '0;
      misses      <= '0;
      idx         <= '0;
      done        <= 1'b0;
    end else begin
      key_prev   <= note_key;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      done       <= 1'b0;
      if (!en) begin
        state    <= IDLE;
        note_led <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              idx    <= '0;
              score  <= '0;
              misses <= '0;
              state  <= FETCH;
            end
          end
          FETCH: state <= LATCH;
          LATCH: begin
            end_flag    <= e_end;
            goal_octave <= e_oct;
            goal_note   <= e_note;
            goal_len    <= e_len;
            timer       <= '0;
            if (e_is_note) begin
              note_led <= note_onehot(e_note);
              state    <= GUIDE;
            end else begin
              note_led <= '0;
              state    <= REST;
            end
          end
          GUIDE: begin
            // A press on the timeout cycle is judged; the timeout is not taken.
            if (any_press) begin
              if (good_press) begin
                hit_pulse <= 1'b1;
                score     <= sat_inc(score);
                note_led  <= '0;
                state     <= ADVANCE;
              end else begin
                miss_pulse <= 1'b1;
                misses     <= sat_inc(misses);
                timer      <= '0;
                if (strict) begin
                  note_led <= '0;
                  state    <= ADVANCE;
                end
              end
            end else if (timer == TIMEOUT_LAST) begin
              miss_pulse <= 1'b1;
              misses     <= sat_inc(misses);
              note_led   <= '0;
              state      <= ADVANCE;
            end else begin
              timer <= timer + TMR_ONE;
            end
          end
          REST: begin
            if (timer == rest_last) state <= ADVANCE;
            else                    timer <= timer + TMR_ONE;
          end
          ADVANCE: begin
            if (end_flag || idx == IDX_LAST) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              idx   <= idx + ADDR_W'(1);
              state <= FETCH;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_study_scorer.sv
// Bench for study_scorer with a small configuration: 4-entry songs, 10-cycle
// timeout, 4-cycle rest unit and 2-bit counters.
module tb_study_scorer;

  localparam int NK = 7;

  logic          clk;
  logic          rst;
  logic          en;
  logic          start;
  logic          strict;
  logic [NK-1:0] note_key;
  logic [1:0]    octave;
  logic [1:0]    rom_addr;
  logic [8:0]    rom_data;
  logic [NK-1:0] note_led;
  logic [1:0]    goal_octave;
  logic          hit_pulse;
  logic          miss_pulse;
  logic [1:0]    score;
  logic [1:0]    misses;
  logic [1:0]    idx;
  logic          busy;
  logic          done;

  study_scorer #(
    .NOTE_KEYS(7), .LEN_BITS(3), .SONG_DEPTH(4),
    .TIMEOUT_CYCLES(10), .REST_UNIT(4), .SCORE_BITS(2)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .strict(strict),
    .note_key(note_key), .octave(octave), .rom_addr(rom_addr),
    .rom_data(rom_data), .note_led(note_led), .goal_octave(goal_octave),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .score(score),
    .misses(misses), .idx(idx), .busy(busy), .done(done)
  );

  // ---------------- clock / ROM model ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [8:0] rom_mem [0:3];
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  // Pulse counters observed on the falling edge.
  int hit_seen, miss_seen, done_seen;
  initial begin hit_seen = 0; miss_seen = 0; done_seen = 0; end
  always @(negedge clk) begin
    if (hit_pulse === 1'b1)  hit_seen++;
    if (miss_pulse === 1'b1) miss_seen++;
    if (done === 1'b1)       done_seen++;
  end

  // ---------------- scoreboard ----------------
  int checks, errors;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [8:0] ent(input logic e, input logic [1:0] o,
                                      input logic [2:0] n, input logic [2:0] l);
    return {e, o, n, l};
  endfunction

  task automatic do_reset();
    rst = 1'b1; en = 1'b1; start = 1'b0; strict = 1'b0;
    note_key = '0; octave = 2'd0;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  // Leaves the bench one step after the third edge: first GUIDE/REST cycle.
  task automatic start_run();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(2);
  endtask

  task automatic check_reset(input string tag);
    check({tag, " rom_addr"},    32'(rom_addr), 32'd0);
    check({tag, " note_led"},    32'(note_led), 32'd0);
    check({tag, " goal_octave"}, 32'(goal_octave), 32'd0);
    check({tag, " hit_pulse"},   32'(hit_pulse), 32'd0);
    check({tag, " miss_pulse"},  32'(miss_pulse), 32'd0);
    check({tag, " score"},       32'(score), 32'd0);
    check({tag, " misses"},      32'(misses), 32'd0);
    check({tag, " idx"},         32'(idx), 32'd0);
    check({tag, " busy"},        32'(busy), 32'd0);
    check({tag, " done"},        32'(done), 32'd0);
  endtask

  // ---------------- judgement vectors ----------------
  typedef struct {
    logic [2:0]    g_note;
    logic [1:0]    g_oct;
    logic          strict_v;
    logic [NK-1:0] key;
    logic [1:0]    oct;
    logic [NK-1:0] exp_led;
    logic          exp_hit;
    logic          exp_miss;
    logic [NK-1:0] exp_led_after;
    logic [1:0]    exp_idx;
  } vec_t;

  vec_t vecs [10];

  initial begin
    automatic int h0, m0, d0;
    checks = 0; errors = 0;
    for (int i = 0; i < 4; i++) rom_mem[i] = '0;

    vecs[0] = '{3'd3, 2'd1, 1'b0, 7'b0000100, 2'd1, 7'b0000100, 1'b1, 1'b0, 7'b0000000, 2'd1};
    vecs[1] = '{3'd3, 2'd1, 1'b0, 7'b0000001, 2'd1, 7'b0000100, 1'b0, 1'b1, 7'b0000100, 2'd0};
    vecs[2] = '{3'd3, 2'd1, 1'b1, 7'b0000100, 2'd2, 7'b0000100, 1'b0, 1'b1, 7'b0000000, 2'd1};
    vecs[3] = '{3'd3, 2'd1, 1'b1, 7'b0000110, 2'd1, 7'b0000100, 1'b0, 1'b1, 7'b0000000, 2'd1};
    vecs[4] = '{3'd3, 2'd1, 1'b0, 7'b0000110, 2'd1, 7'b0000100, 1'b0, 1'b1, 7'b0000100, 2'd0};
    vecs[5] = '{3'd7, 2'd3, 1'b1, 7'b1000000, 2'd3, 7'b1000000, 1'b1, 1'b0, 7'b0000000, 2'd1};
    vecs[6] = '{3'd1, 2'd0, 1'b0, 7'b0000001, 2'd0, 7'b0000001, 1'b1, 1'b0, 7'b0000000, 2'd1};
    vecs[7] = '{3'd5, 2'd2, 1'b1, 7'b0010000, 2'd2, 7'b0010000, 1'b1, 1'b0, 7'b0000000, 2'd1};
    vecs[8] = '{3'd5, 2'd2, 1'b1, 7'b0001000, 2'd2, 7'b0010000, 1'b0, 1'b1, 7'b0000000, 2'd1};
    vecs[9] = '{3'd6, 2'd2, 1'b0, 7'b0100000, 2'd1, 7'b0100000, 1'b0, 1'b1, 7'b0100000, 2'd0};

    // Reset values
    rst = 1'b1; en = 1'b1; start = 1'b0; strict = 1'b0; note_key = '0; octave = 2'd0;
    tick(1);
    check_reset("reset");
    rst = 1'b0;
    tick(1);

    // Table: one judgement per fresh run
    for (int i = 0; i < 10; i++) begin
      do_reset();
      strict = vecs[i].strict_v;
      rom_mem[0] = ent(1'b0, vecs[i].g_oct, vecs[i].g_note, 3'd0);
      rom_mem[1] = ent(1'b1, 2'd0, 3'd1, 3'd0);
      start_run();
      check($sformatf("v%0d led", i), 32'(note_led), 32'(vecs[i].exp_led));
      check($sformatf("v%0d goal_octave", i), 32'(goal_octave), 32'(vecs[i].g_oct));
      note_key = vecs[i].key;
      octave   = vecs[i].oct;
      tick(1);
      check($sformatf("v%0d hit_pulse", i), 32'(hit_pulse), 32'(vecs[i].exp_hit));
      check($sformatf("v%0d miss_pulse", i), 32'(miss_pulse), 32'(vecs[i].exp_miss));
      check($sformatf("v%0d score", i), 32'(score), 32'(vecs[i].exp_hit));
      check($sformatf("v%0d misses", i), 32'(misses), 32'(vecs[i].exp_miss));
      check($sformatf("v%0d led_after", i), 32'(note_led), 32'(vecs[i].exp_led_after));
      note_key = '0;
      tick(3);
      check($sformatf("v%0d idx", i), 32'(idx), 32'(vecs[i].exp_idx));
    end

    // Two-entry song, two hits, done once; start ignored mid-run
    do_reset();
    strict = 1'b1;
    rom_mem[0] = ent(1'b0, 2'd1, 3'd3, 3'd0);
    rom_mem[1] = ent(1'b1, 2'd1, 3'd5, 3'd0);
    h0 = hit_seen; m0 = miss_seen; d0 = done_seen;
    start_run();
    check("song busy", 32'(busy), 32'd1);
    octave = 2'd1; note_key = 7'b0000100;
    tick(1);
    check("song hit1", 32'(hit_pulse), 32'd1);
    note_key = '0;
    tick(3);
    check("song led2", 32'(note_led), 32'(7'b0010000));
    check("song idx2", 32'(idx), 32'd1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    check("start ignored led", 32'(note_led), 32'(7'b0010000));
    check("start ignored score", 32'(score), 32'd1);
    note_key = 7'b0010000;
    tick(1);
    check("song hit2", 32'(hit_pulse), 32'd1);
    note_key = '0;
    tick(1);
    check("song done", 32'(done), 32'd1);
    check("song done idx", 32'(idx), 32'd1);
    tick(1);
    check("song done low", 32'(done), 32'd0);
    check("song idle", 32'(busy), 32'd0);
    check("song score", 32'(score), 32'd2);
    check("song misses", 32'(misses), 32'd0);
    tick(2);
    check("song hits seen", 32'(hit_seen - h0), 32'd2);
    check("song misses seen", 32'(miss_seen - m0), 32'd0);
    check("song done seen", 32'(done_seen - d0), 32'd1);

    // Key held into GUIDE is not a press; release and re-press is
    do_reset();
    rom_mem[0] = ent(1'b0, 2'd1, 3'd3, 3'd0);
    rom_mem[1] = ent(1'b1, 2'd0, 3'd1, 3'd0);
    octave = 2'd1; note_key = 7'b0000100;
    h0 = hit_seen; m0 = miss_seen;
    start_run();
    tick(2);
    check("held no hit", 32'(hit_seen - h0), 32'd0);
    check("held no miss", 32'(miss_seen - m0), 32'd0);
    check("held led", 32'(note_led), 32'(7'b0000100));
    note_key = '0;
    tick(1);
    note_key = 7'b0000100;
    tick(1);
    check("repress hit", 32'(hit_pulse), 32'd1);
    note_key = '0;

    // Lenient mode: wrong press retries, then correct press advances
    do_reset();
    strict = 1'b0;
    rom_mem[0] = ent(1'b0, 2'd1, 3'd3, 3'd0);
    rom_mem[1] = ent(1'b1, 2'd0, 3'd1, 3'd0);
    start_run();
    octave = 2'd1; note_key = 7'b0000001;
    tick(1);
    check("retry miss", 32'(miss_pulse), 32'd1);
    check("retry led", 32'(note_led), 32'(7'b0000100));
    note_key = '0;
    tick(1);
    note_key = 7'b0000100;
    tick(1);
    check("retry hit", 32'(hit_pulse), 32'd1);
    check("retry score", 32'(score), 32'd1);
    check("retry misses", 32'(misses), 32'd1);
    note_key = '0;
    tick(3);
    check("retry idx", 32'(idx), 32'd1);

    // Timeout exactly 10 cycles after GUIDE entry; press on the last cycle wins
    do_reset();
    strict = 1'b1;
    rom_mem[0] = ent(1'b0, 2'd1, 3'd3, 3'd0);
    rom_mem[1] = ent(1'b1, 2'd1, 3'd3, 3'd0);
    m0 = miss_seen;
    start_run();
    tick(9);
    check("timeout early", 32'(miss_pulse), 32'd0);
    check("timeout early led", 32'(note_led), 32'(7'b0000100));
    tick(1);
    check("timeout miss", 32'(miss_pulse), 32'd1);
    check("timeout misses", 32'(misses), 32'd1);
    check("timeout led off", 32'(note_led), 32'd0);
    tick(3);
    check("timeout next idx", 32'(idx), 32'd1);
    tick(9);
    octave = 2'd1; note_key = 7'b0000100;
    tick(1);
    check("late press hit", 32'(hit_pulse), 32'd1);
    check("late press no miss", 32'(miss_pulse), 32'd0);
    note_key = '0;
    tick(2);
    check("timeout misses seen", 32'(miss_seen - m0), 32'd1);

    // Rest of length 2: LED dark for 12 cycles, no scoring
    do_reset();
    rom_mem[0] = ent(1'b0, 2'd0, 3'd0, 3'd2);
    rom_mem[1] = ent(1'b1, 2'd0, 3'd2, 3'd0);
    h0 = hit_seen; m0 = miss_seen;
    start_run();
    check("rest led", 32'(note_led), 32'd0);
    check("rest busy", 32'(busy), 32'd1);
    tick(11);
    check("rest led late", 32'(note_led), 32'd0);
    check("rest idx late", 32'(idx), 32'd0);
    tick(3);
    check("rest latch led", 32'(note_led), 32'd0);
    tick(1);
    check("rest next led", 32'(note_led), 32'(7'b0000010));
    check("rest next idx", 32'(idx), 32'd1);
    check("rest pulses", 32'((hit_seen - h0) + (miss_seen - m0)), 32'd0);

    // Four entries without end flag; score saturates at 3, done after idx 3
    do_reset();
    strict = 1'b1;
    for (int i = 0; i < 4; i++) rom_mem[i] = ent(1'b0, 2'(i), 3'(i + 1), 3'd0);
    d0 = done_seen;
    start_run();
    for (int k = 0; k < 4; k++) begin
      automatic logic [NK-1:0] kb = NK'(1) << k;
      check($sformatf("depth led%0d", k), 32'(note_led), 32'(kb));
      octave = 2'(k); note_key = kb;
      tick(1);
      check($sformatf("depth hit%0d", k), 32'(hit_pulse), 32'd1);
      check($sformatf("depth score%0d", k), 32'(score), (k + 1 > 3) ? 32'd3 : 32'(k + 1));
      note_key = '0;
      if (k < 3) tick(3);
    end
    tick(1);
    check("depth done", 32'(done), 32'd1);
    check("depth idx", 32'(idx), 32'd3);
    tick(1);
    check("depth idle", 32'(busy), 32'd0);
    check("depth done seen", 32'(done_seen - d0), 32'd1);

    // Miss counter saturation, then en low mid-GUIDE
    do_reset();
    strict = 1'b0;
    rom_mem[0] = ent(1'b0, 2'd1, 3'd3, 3'd0);
    rom_mem[1] = ent(1'b1, 2'd1, 3'd3, 3'd0);
    start_run();
    octave = 2'd1;
    for (int k = 0; k < 5; k++) begin
      note_key = 7'b0000001;
      tick(1);
      check($sformatf("sat miss%0d", k), 32'(miss_pulse), 32'd1);
      note_key = '0;
      tick(1);
    end
    check("sat misses", 32'(misses), 32'd3);
    en = 1'b0; note_key = 7'b0000100;
    tick(1);
    check("en off led", 32'(note_led), 32'd0);
    check("en off busy", 32'(busy), 32'd0);
    check("en off hit", 32'(hit_pulse), 32'd0);
    check("en off score", 32'(score), 32'd0);
    check("en off misses", 32'(misses), 32'd3);
    note_key = '0; en = 1'b1;
    tick(2);
    check("en back idle", 32'(busy), 32'd0);

    // Reset mid-run
    do_reset();
    rom_mem[0] = ent(1'b0, 2'd1, 3'd3, 3'd0);
    rom_mem[1] = ent(1'b1, 2'd1, 3'd5, 3'd0);
    start_run();
    octave = 2'd1; note_key = 7'b0000100;
    tick(1);
    note_key = '0;
    tick(3);
    check("pre-rst idx", 32'(idx), 32'd1);
    d0 = done_seen;
    #2 rst = 1'b1;
    #1 check_reset("mid-run rst");
    tick(2);
    rst = 1'b0;
    tick(3);
    check("rst no done", 32'(done_seen - d0), 32'd0);
    check("rst stays idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
